multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_MAX, 15, maximum wait cycles for imem_ready/dmem_ready before bus error (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst  input  32  current instruction register contents.
REQ-005 br_taken  input  1  branch comparator result, valid in EXEC.
REQ-006 imem_ready / dmem_ready  input  1 each  memory completion strobes.
REQ-007 imem_req / dmem_req / dmem_we  output  1 each  memory requests; dmem_we=1 for stores.
REQ-008 ir_we, pc_we, reg_we  output  1 each  instruction register, PC and register file write enables.
REQ-009 pc_sel  output  2  next PC: 0 pc+4, 1 pc+imm, 2 ALU result with bit0 cleared.
REQ-010 immtype  output  3  to immediate generator: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-011 alu_srca / alu_srcb  output  1 each  srca 0=rs1, 1=PC; srcb 0=rs2, 1=imm.
REQ-012 wb_sel  output  2  writeback source: 0 ALU, 1 load data, 2 pc+4, 3 imm.
REQ-013 illegal, bus_err  output  1 each  sticky trap flags.

Function
REQ-014 States: FETCH, DECODE, EXEC, MEM, WB, TRAP, encoded in 3 bits.
REQ-015 FETCH: imem_req held high until imem_ready; in the imem_ready cycle, ir_we pulses for one cycle, then DECODE.
REQ-016 DECODE: one cycle; immtype/alu_src driven from inst[6:0]; opcode outside the set {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} -> TRAP with illegal=1.
REQ-017 Opcode -> immtype: OP-IMM/LOAD/JALR I; STORE S; BRANCH B; LUI/AUIPC U; JAL J; OP drives 000.
REQ-018 EXEC, BRANCH: pc_we=1, pc_sel=1 if br_taken else 0 -> FETCH.
REQ-019 EXEC, JAL: reg_we, wb_sel=2, pc_we, pc_sel=1 -> FETCH; JALR same with pc_sel=2, alu_srca=0, alu_srcb=1.
REQ-020 EXEC, LOAD/STORE: alu_srcb=1 (address calculation) -> MEM; OP/OP-IMM/LUI/AUIPC -> WB.
REQ-021 MEM: dmem_req held (dmem_we=1 for STORE) until dmem_ready; STORE then pc_we, pc_sel=0 -> FETCH; LOAD -> WB.
REQ-022 WB: reg_we=1, pc_we=1, pc_sel=0, wb_sel per opcode (OP/OP-IMM/AUIPC 0, LOAD 1, LUI 3) -> FETCH; AUIPC uses alu_srca=1, alu_srcb=1.
REQ-023 reg_we is suppressed whenever inst[11:7]==0.
REQ-024 Wait counter (8 bit): clears on state entry and in any cycle with ready; increments each cycle a req is high without ready; reaching MEM_WAIT_MAX -> TRAP with bus_err=1; ready arriving in the same cycle the limit is reached wins (no error).
REQ-025 TRAP: all enables and requests 0; remains until rst.
REQ-026 Outputs are combinational from state and inst (Moore/Mealy on ready only); req outputs never depend combinationally on ready.
REQ-027 Exactly one of pc_we per retired instruction; ir_we and pc_we never both high.

Reset
REQ-028 rst in any state, including mid-handshake, -> FETCH next edge; counter=0, illegal=0, bus_err=0; all write enables and dmem_req 0 during the reset cycle; imem_req 0 during reset and 1 in the first post-reset cycle.

Structure
REQ-029 Shared package/header: opcode constants, immtype codes, pc_sel/wb_sel codes, state encodings; also used by immgen and datapath.
REQ-030 One sub-module natural: ctrl_wait_timer (counter + limit compare).

Verification
REQ-031 ADDI x1,x0,5 (0x00500093), imem_ready at 1st request -> FETCH,DECODE,EXEC,WB; immtype=000, reg_we with wb_sel=0 in WB; 4 cycles total.
REQ-032 BEQ, br_taken=1 -> EXEC pc_we=1, pc_sel=1, immtype=010; br_taken=0 -> pc_sel=0; no reg_we.
REQ-033 LW with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=1.
REQ-034 inst=0xFFFFFFFF -> TRAP after DECODE, illegal=1, no enables thereafter.
REQ-035 MEM_WAIT_MAX=15, imem_ready held low -> bus_err=1 after 15 wait cycles; ready on the 15th cycle -> no error.
REQ-036 rst asserted during MEM of SW -> next cycle FETCH, dmem_req=0, flags clear.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes, field codes,
// state encoding and the control-word payload.
package multicycle_ctrl_pkg;

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned OPC_W   = 7;

    // Base opcodes recognised by the controller
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    // Immediate generator format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    // Register writeback source
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Control word driven toward memories and datapath
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic [1:0] pc_sel;
        logic [2:0] immtype;
        logic       alu_srca;
        logic       alu_srcb;
        logic [1:0] wb_sel;
    } ctrl_t;

    // True for opcodes the controller can sequence
    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LUI)   || (opc == OPC_AUIPC) || (opc == OPC_JAL)   ||
               (opc == OPC_JALR)  || (opc == OPC_BRANCH)|| (opc == OPC_LOAD)  ||
               (opc == OPC_STORE) || (opc == OPC_OPIMM) || (opc == OPC_OP);
    endfunction

    // Immediate format per opcode; R-type and unknowns fall back to I
    function automatic logic [2:0] opc_immtype(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_STORE:            return IMM_S;
            OPC_BRANCH:           return IMM_B;
            OPC_LUI, OPC_AUIPC:   return IMM_U;
            OPC_JAL:              return IMM_J;
            default:              return IMM_I;
        endcase
    endfunction

    // ALU operand B takes the immediate for everything except R-type, branch and JAL
    function automatic logic opc_srcb_imm(input logic [OPC_W-1:0] opc);
        return (opc == OPC_OPIMM) || (opc == OPC_LOAD) || (opc == OPC_STORE) ||
               (opc == OPC_JALR)  || (opc == OPC_LUI)  || (opc == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory handshake watchdog: counts cycles a request waits without ready.
module ctrl_wait_timer
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire_c
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_WAIT_MAX - 1);

    logic [WAIT_W-1:0] r_count;

    // Wait-cycle counter; clear wins over increment
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    // This waiting cycle is the MEM_WAIT_MAX-th one; a ready in it suppresses i_inc
    assign o_expire_c = i_inc && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky trap flags.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic        i_br_taken,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_reg_we,
    output logic [1:0]  o_pc_sel,
    output logic [2:0]  o_immtype,
    output logic        o_alu_srca,
    output logic        o_alu_srcb,
    output logic [1:0]  o_wb_sel,
    output logic        o_illegal,
    output logic        o_bus_err
);

    state_t           r_state;
    state_t           w_next;
    ctrl_t            w_ctrl;
    logic [OPC_W-1:0] w_opc;
    logic             w_rd_zero;
    logic             w_imem_req;
    logic             w_dmem_req;
    logic             w_ready;
    logic             w_inc;
    logic             w_clr;
    logic             w_timeout;
    logic             w_set_illegal;
    logic             w_set_bus_err;
    logic             r_illegal;
    logic             r_bus_err;
    logic             w_unused_inst;

    assign w_opc         = i_inst[6:0];
    assign w_rd_zero     = (i_inst[11:7] == 5'd0);
    assign w_unused_inst = ^i_inst[31:12];

    // Requests depend on state only, so ready can never loop back into them
    assign w_imem_req = (r_state == S_FETCH) && !i_rst;
    assign w_dmem_req = (r_state == S_MEM)   && !i_rst;
    assign w_ready    = (w_imem_req && i_imem_ready) || (w_dmem_req && i_dmem_ready);
    assign w_inc      = (w_imem_req && !i_imem_ready) || (w_dmem_req && !i_dmem_ready);
    assign w_clr      = w_ready || (w_next != r_state);

    ctrl_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_inc      (w_inc),
        .o_expire_c (w_timeout)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky trap flags, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_bus_err) r_bus_err <= 1'b1;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next        = r_state;
        w_ctrl        = '0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;

        if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            w_ctrl.immtype  = opc_immtype(w_opc);
            w_ctrl.alu_srca = (w_opc == OPC_AUIPC);
            w_ctrl.alu_srcb = opc_srcb_imm(w_opc);
        end

        case (r_state)
            S_FETCH: begin
                w_ctrl.imem_req = 1'b1;
                if (i_imem_ready) begin
                    w_ctrl.ir_we = 1'b1;
                    w_next       = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_DECODE: begin
                if (opc_legal(w_opc)) begin
                    w_next = S_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_EXEC: begin
                case (w_opc)
                    OPC_BRANCH: begin
                        w_ctrl.pc_we  = 1'b1;
                        w_ctrl.pc_sel = i_br_taken ? PC_IMM : PC_PLUS4;
                        w_next        = S_FETCH;
                    end
                    OPC_JAL, OPC_JALR: begin
                        w_ctrl.reg_we = 1'b1;
                        w_ctrl.wb_sel = WB_PC4;
                        w_ctrl.pc_we  = 1'b1;
                        w_ctrl.pc_sel = (w_opc == OPC_JAL) ? PC_IMM : PC_ALU;
                        w_next        = S_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        w_next = S_MEM;
                    end
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                        w_next = S_WB;
                    end
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                w_ctrl.dmem_req = 1'b1;
                w_ctrl.dmem_we  = (w_opc == OPC_STORE);
                if (i_dmem_ready) begin
                    if (w_opc == OPC_STORE) begin
                        w_ctrl.pc_we  = 1'b1;
                        w_ctrl.pc_sel = PC_PLUS4;
                        w_next        = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_WB: begin
                w_ctrl.reg_we = 1'b1;
                w_ctrl.pc_we  = 1'b1;
                w_ctrl.pc_sel = PC_PLUS4;
                case (w_opc)
                    OPC_LOAD: w_ctrl.wb_sel = WB_LOAD;
                    OPC_LUI:  w_ctrl.wb_sel = WB_IMM;
                    default:  w_ctrl.wb_sel = WB_ALU;
                endcase
                w_next = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // x0 is never written
        if (w_rd_zero) begin
            w_ctrl.reg_we = 1'b0;
        end

        // Reset cycle: no requests, no enables, no state advance
        if (i_rst) begin
            w_ctrl        = '0;
            w_set_illegal = 1'b0;
            w_set_bus_err = 1'b0;
            w_next        = S_FETCH;
        end
    end

    assign o_imem_req = w_ctrl.imem_req;
    assign o_dmem_req = w_ctrl.dmem_req;
    assign o_dmem_we  = w_ctrl.dmem_we;
    assign o_ir_we    = w_ctrl.ir_we;
    assign o_pc_we    = w_ctrl.pc_we;
    assign o_reg_we   = w_ctrl.reg_we;
    assign o_pc_sel   = w_ctrl.pc_sel;
    assign o_immtype  = w_ctrl.immtype;
    assign o_alu_srca = w_ctrl.alu_srca;
    assign o_alu_srcb = w_ctrl.alu_srcb;
    assign o_wb_sel   = w_ctrl.wb_sel;
    assign o_illegal  = r_illegal;
    assign o_bus_err  = r_bus_err;

endmodule
